// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
// Data has fixed priority, fetch is forced after MAX_SKIP data grants; BUSY transactions time out.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_SKIP = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              bus_err
);

  localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
  localparam int TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                own_data_q, own_data_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                bus_err_q, bus_err_d;

  logic d_req_s;
  logic skip_at_max_s;
  logic data_win_s;

  assign d_req_s       = d_read | d_write;
  assign skip_at_max_s = (skip_q == SKIP_MAX);
  // a waiting fetch that has been passed over MAX_SKIP times beats data
  assign data_win_s    = d_req_s & ~(if_req & skip_at_max_s);

  // Next-state, memory-port and completion logic for the transaction sequencer
  always_comb begin
    state_d    = state_q;
    own_data_d = own_data_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (data_win_s) begin
          own_data_d = 1'b1;
          m_req_d    = 1'b1;
          m_we_d     = d_write;
          m_addr_d   = d_addr;
          m_wdata_d  = d_wdata;
          tmo_d      = '0;
          state_d    = S_BUSY;
          if (if_req && !skip_at_max_s) begin
            skip_d = skip_q + SKIP_W'(1);
          end else begin
            skip_d = skip_q;
          end
        end else if (if_req) begin
          own_data_d = 1'b0;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = if_addr;
          m_wdata_d  = '0;
          tmo_d      = '0;
          skip_d     = '0;
          state_d    = S_BUSY;
        end else begin
          m_req_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          state_d = S_DONE;
          if (own_data_q) begin
            d_done_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = m_rdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          // abort: the requester still sees a completion, but with zeroed data
          bus_err_d = 1'b1;
          m_req_d   = 1'b0;
          state_d   = S_DONE;
          if (own_data_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      own_data_q <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      skip_q     <= '0;
      tmo_q      <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign bus_err  = bus_err_q;
  assign if_stall = if_req & ~if_done_q;
  assign d_stall  = d_req_s & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants and
// completions, a memory responder serves the port, and a monitor compares DUT outputs.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_SKIP = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic if_done, if_stall;
  logic d_read = 1'b0;
  logic d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic d_done, d_stall;
  logic m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic m_ready = 1'b0;
  logic bus_err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_SKIP(MAX_SKIP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic rd; logic wr; int gap; } req_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } grant_t;
  typedef struct { logic is_data; logic [31:0] if_rd; logic [31:0] d_rd; logic berr; } done_t;

  req_t   f_q[$];
  req_t   d_q[$];
  grant_t g_q[$];
  done_t  dn_q[$];
  int     delay_q[$];
  int     force_q[$];
  logic   done_log[$];
  logic [31:0] mem_img [logic [31:0]];
  int checks = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    failures++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    else return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] wd,
                                  input logic rd, input logic wr, input int gap);
    req_t r;
    r.addr = a; r.wdata = wd; r.rd = rd; r.wr = wr; r.gap = gap;
    return r;
  endfunction

  function automatic int rand_delay();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return int'($urandom_range(0, 3));
    else if (r < 85) return int'($urandom_range(4, 15));
    else return int'($urandom_range(16, 20));
  endfunction

  // fetch requester: holds if_req until if_done, then moves to its next queued item
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      if_req = 1'b0;
      f_q.delete();
    end else begin
      if (if_req && if_done) if_req = 1'b0;
      if (!if_req && f_q.size() > 0) begin
        if (f_q[0].gap > 0) f_q[0].gap = f_q[0].gap - 1;
        else begin
          if_addr = f_q[0].addr;
          if_req = 1'b1;
          void'(f_q.pop_front());
        end
      end
    end
  end

  // data requester
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      d_read = 1'b0; d_write = 1'b0;
      d_q.delete();
    end else begin
      if ((d_read || d_write) && d_done) begin d_read = 1'b0; d_write = 1'b0; end
      if (!d_read && !d_write && d_q.size() > 0) begin
        if (d_q[0].gap > 0) d_q[0].gap = d_q[0].gap - 1;
        else begin
          d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
          d_read = d_q[0].rd; d_write = d_q[0].wr;
          void'(d_q.pop_front());
        end
      end
    end
  end

  // memory responder: answers after the delay chosen for this transaction, plus stray m_ready pulses while idle
  initial begin
    int cnt;
    int dly;
    cnt = 0; dly = 0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      if (!reset_n) begin
        cnt = 0;
        delay_q.delete();
      end else if (m_req) begin
        if (cnt == 0) dly = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        cnt++;
        if (cnt == dly + 1) begin
          m_ready = 1'b1;
          if (m_we) mem_img[m_addr] = m_wdata;
          else m_rdata = mem_val(m_addr);
        end else begin
          m_rdata = $urandom();
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 7) == 0) begin
          m_ready = 1'b1;
          m_rdata = $urandom();
        end
      end
    end
  end

  // reference model: one arbitration decision per free slot, transaction length from the memory delay
  initial begin
    int busy_left;
    int skip;
    int dly;
    logic berr, take_data, tmo;
    logic [31:0] last_if, last_d;
    grant_t g;
    done_t e;
    busy_left = 0; skip = 0; berr = 1'b0; last_if = '0; last_d = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        busy_left = 0; skip = 0; berr = 1'b0; last_if = '0; last_d = '0;
        g_q.delete(); dn_q.delete();
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (if_req || d_read || d_write) begin
        take_data = (d_read || d_write) && !(if_req && skip == MAX_SKIP);
        dly = (force_q.size() > 0) ? force_q.pop_front() : rand_delay();
        tmo = (dly >= TIMEOUT);
        if (take_data) begin
          g.addr = d_addr; g.we = d_write; g.wdata = d_wdata;
          if (if_req && skip < MAX_SKIP) skip++;
        end else begin
          g.addr = if_addr; g.we = 1'b0; g.wdata = '0;
          skip = 0;
        end
        if (tmo) begin
          berr = 1'b1;
          if (take_data) last_d = '0; else last_if = '0;
        end else if (!take_data) last_if = mem_val(g.addr);
        else if (!g.we) last_d = mem_val(g.addr);
        else last_d = last_d;
        e.is_data = take_data; e.if_rd = last_if; e.d_rd = last_d; e.berr = berr;
        g_q.push_back(g);
        dn_q.push_back(e);
        delay_q.push_back(dly);
        busy_left = (tmo ? TIMEOUT : dly + 1) + 1;
      end
    end
  end

  // monitor: compares grants on m_req rise and completions on done pulses
  initial begin
    logic prev_req;
    grant_t cur;
    done_t e;
    prev_req = 1'b0;
    cur.addr = '0; cur.we = 1'b0; cur.wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        prev_req = 1'b0;
      end else begin
        chk1("if_stall", if_stall, if_req & ~if_done);
        chk1("d_stall", d_stall, (d_read | d_write) & ~d_done);
        if (m_req && !prev_req) begin
          if (g_q.size() == 0) fail($sformatf("grant unexpected m_req addr=%h", m_addr));
          else begin
            cur = g_q.pop_front();
            chk32("m_addr", m_addr, cur.addr);
            chk1("m_we", m_we, cur.we);
            if (cur.we) chk32("m_wdata", m_wdata, cur.wdata);
          end
        end else if (m_req) begin
          chk32("m_addr_stable", m_addr, cur.addr);
          chk1("m_we_stable", m_we, cur.we);
        end
        prev_req = m_req;
        if (if_done && d_done) fail("done both if_done and d_done high");
        if (if_done || d_done) begin
          if (dn_q.size() == 0) fail($sformatf("done unexpected if_done=%b d_done=%b", if_done, d_done));
          else begin
            e = dn_q.pop_front();
            chk1("done_owner", d_done, e.is_data);
            chk32("if_rdata", if_rdata, e.if_rd);
            chk32("d_rdata", d_rdata, e.d_rd);
            chk1("bus_err", bus_err, e.berr);
            done_log.push_back(d_done);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (n < budget && !(f_q.size() == 0 && d_q.size() == 0 && !if_req &&
                               !d_read && !d_write && dn_q.size() == 0));
    if (n >= budget) fail($sformatf("wait_idle budget %0d expired", budget));
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_log(input string name, input logic exp[$]);
    chk32({name, "_len"}, 32'(done_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < done_log.size(); i++)
      chk1($sformatf("%s_%0d", name, i), done_log[i], exp[i]);
  endtask

  initial begin
    logic exp_log[$];
    int n;
    mem_img[32'h40] = 32'h8C220004;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk32("rst_m_addr", m_addr, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    #1;
    reset_n = 1'b1;

    // single fetch, memory answers one cycle after m_req
    force_q.push_back(1);
    f_q.push_back(mk_req(32'h40, 32'h0, 1'b0, 1'b0, 0));
    wait_idle(200);
    chk32("fetch_rdata", if_rdata, 32'h8C220004);

    // simultaneous fetch and load: load first
    done_log.delete();
    d_q.push_back(mk_req(32'h100, 32'h0, 1'b1, 1'b0, 0));
    f_q.push_back(mk_req(32'h44, 32'h0, 1'b0, 1'b0, 0));
    wait_idle(200);
    exp_log = '{1'b1, 1'b0};
    chk_log("simul_order", exp_log);

    // starvation bound: four data grants, then the waiting fetch
    done_log.delete();
    for (int i = 0; i < 6; i++) d_q.push_back(mk_req(32'h1000 + 32'(4 * i), 32'h0, 1'b1, 1'b0, 0));
    f_q.push_back(mk_req(32'h80, 32'h0, 1'b0, 1'b0, 0));
    wait_idle(400);
    exp_log = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    chk_log("starve_order", exp_log);

    // store then load-back
    d_q.push_back(mk_req(32'h200, 32'hDEADBEEF, 1'b0, 1'b1, 0));
    d_q.push_back(mk_req(32'h200, 32'h0, 1'b1, 1'b0, 0));
    wait_idle(200);
    chk32("store_readback", d_rdata, 32'hDEADBEEF);

    // timeout, then a good fetch answered in the last BUSY cycle
    force_q.push_back(20);
    d_q.push_back(mk_req(32'h300, 32'h0, 1'b1, 1'b0, 0));
    wait_idle(200);
    chk1("tmo_bus_err", bus_err, 1'b1);
    chk32("tmo_d_rdata", d_rdata, 32'h0);
    force_q.push_back(TIMEOUT - 1);
    f_q.push_back(mk_req(32'h40, 32'h0, 1'b0, 1'b0, 0));
    wait_idle(200);
    chk1("sticky_bus_err", bus_err, 1'b1);
    chk32("late_ready_rdata", if_rdata, 32'h8C220004);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      f_q.push_back(mk_req({22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0, 1'b0, 1'b0,
                           int'($urandom_range(0, 3))));
      n = int'($urandom_range(0, 3));
      d_q.push_back(mk_req({22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom(),
                           n != 2, n >= 2, int'($urandom_range(0, 3))));
    end
    wait_idle(20000);

    // reset while BUSY
    force_q.push_back(40);
    f_q.push_back(mk_req(32'h300, 32'h0, 1'b0, 1'b0, 0));
    n = 0;
    while (!m_req && n < 50) begin @(posedge clk); n++; end
    if (!m_req) fail("reset_test m_req never rose");
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("async_m_req", m_req, 1'b0);
    chk1("async_if_done", if_done, 1'b0);
    chk1("async_d_done", d_done, 1'b0);
    chk1("async_bus_err", bus_err, 1'b0);
    chk32("async_if_rdata", if_rdata, 32'h0);
    chk32("async_d_rdata", d_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    done_log.delete();
    force_q.push_back(0);
    f_q.push_back(mk_req(32'h40, 32'h0, 1'b0, 1'b0, 0));
    wait_idle(200);
    exp_log = '{1'b0};
    chk_log("post_reset", exp_log);
    chk1("post_reset_bus_err", bus_err, 1'b0);

    chk32("grant_queue_empty", 32'(g_q.size()), 32'd0);
    chk32("done_queue_empty", 32'(dn_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
